// File: rtl/i2s_slave_rx_pkg.sv
// Shared definitions for the I2S slave receiver: FSM encoding, default sample
// width and I2S channel (word-select) levels.
package i2s_slave_rx_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_WAIT_L = 2'd1,
    ST_RECV   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous input, with async active-low
// reset to a selectable initial level.
module i2s_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: recovers left/right PCM words from an external BCK/LCK/DIN
// stream into the CLK domain and presents them as a pair with a VALID strobe.
module i2s_slave_rx
  import i2s_slave_rx_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             BCK,
  input  logic             LCK,
  input  logic             DIN,
  output logic [WIDTH-1:0] L_SMP,
  output logic [WIDTH-1:0] R_SMP,
  output logic             VALID,
  output logic             LOCKED
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic bck_s, lck_s, din_s;

  i2s_sync #(.INIT(1'b0)) u_sync_bck (.clk(CLK), .rst_n(RSTN), .d(BCK), .q(bck_s));
  i2s_sync #(.INIT(1'b0)) u_sync_lck (.clk(CLK), .rst_n(RSTN), .d(LCK), .q(lck_s));
  i2s_sync #(.INIT(1'b0)) u_sync_din (.clk(CLK), .rst_n(RSTN), .d(DIN), .q(din_s));

  logic             bck_prev_q, bck_prev_d;
  logic             rise_q, rise_d;
  logic             smp_lck_q, smp_lck_d;
  logic             smp_din_q, smp_din_d;
  logic             lck_prev_q, lck_prev_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] l_smp_q, l_smp_d;
  logic [WIDTH-1:0] r_smp_q, r_smp_d;
  logic             valid_q, valid_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  rx_state_e        state_q, state_d;

  logic [WIDTH-1:0] sh_app;
  logic [CW-1:0]    cnt_app;
  logic [WIDTH-1:0] word;
  logic             expired;

  always_comb begin
    bck_prev_d = bck_s;
    rise_d     = bck_s & ~bck_prev_q;
    smp_lck_d  = rise_d ? lck_s : smp_lck_q;
    smp_din_d  = rise_d ? din_s : smp_din_q;

    lck_prev_d = lck_prev_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    shadow_d   = shadow_q;
    l_smp_d    = l_smp_q;
    r_smp_d    = r_smp_q;
    valid_d    = 1'b0;
    state_d    = state_q;

    // Bits beyond WIDTH in a long slot are dropped; the count saturates.
    if (bitcnt_q < CW'(WIDTH)) begin
      sh_app  = {shift_q[WIDTH-2:0], smp_din_q};
      cnt_app = bitcnt_q + CW'(1);
    end else begin
      sh_app  = shift_q;
      cnt_app = bitcnt_q;
    end
    word = sh_app << (CW'(WIDTH) - cnt_app);

    tmo_d = tmo_q;
    if (rise_q)
      tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT))
      tmo_d = tmo_q + TW'(1);
    expired = !rise_q && (tmo_q >= TW'(TIMEOUT - 1));

    if (rise_q) begin
      if (smp_lck_q != lck_prev_q) begin
        lck_prev_d = smp_lck_q;
        shift_d    = '0;
        bitcnt_d   = '0;
        unique case (state_q)
          ST_SYNC: state_d = ST_WAIT_L;
          ST_WAIT_L: begin
            if (lck_prev_q == CH_LEFT) begin
              shadow_d = word;
              state_d  = ST_RECV;
            end
          end
          ST_RECV: begin
            if (lck_prev_q == CH_LEFT) begin
              shadow_d = word;
            end else if (lck_prev_q == CH_RIGHT) begin
              l_smp_d = shadow_q;
              r_smp_d = word;
              valid_d = 1'b1;
            end
          end
          default: state_d = ST_SYNC;
        endcase
      end else begin
        shift_d  = sh_app;
        bitcnt_d = cnt_app;
      end
    end else if (expired) begin
      state_d  = ST_SYNC;
      shift_d  = '0;
      bitcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bck_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      smp_lck_q  <= 1'b0;
      smp_din_q  <= 1'b0;
      lck_prev_q <= 1'b0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      shadow_q   <= '0;
      l_smp_q    <= '0;
      r_smp_q    <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= '0;
      state_q    <= ST_SYNC;
    end else begin
      bck_prev_q <= bck_prev_d;
      rise_q     <= rise_d;
      smp_lck_q  <= smp_lck_d;
      smp_din_q  <= smp_din_d;
      lck_prev_q <= lck_prev_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      shadow_q   <= shadow_d;
      l_smp_q    <= l_smp_d;
      r_smp_q    <= r_smp_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      state_q    <= state_d;
    end
  end

  assign L_SMP  = l_smp_q;
  assign R_SMP  = r_smp_q;
  assign VALID  = valid_q;
  assign LOCKED = (state_q == ST_RECV);

endmodule
